// File: rtl/demux_1x8_frame_if.sv
// -----------------------------------------------------------------------------
// demux_1x8_frame_if
// Handshake bundle between a word producer and the 1-to-8 frame demultiplexer.
//
// Signals:
//   in_valid    producer -> demux  din (and addr) hold a valid word
//   in_ready    demux -> producer  demux accepts a word this cycle
//   din[W]      producer -> demux  word to store in the target slot
//   addr[3]     producer -> demux  target slot (only with DEMUX_ADDR_EN)
//   frame_valid demux -> consumer  all 8 slots filled, frame is complete
//   frame_ack   consumer -> demux  consumer has taken the frame
//
// Modports: master = producer/consumer side, slave = the demultiplexer.
// Optional macro: DEMUX_ADDR_EN adds the addr signal.
// -----------------------------------------------------------------------------
interface demux_1x8_frame_if #(
   parameter int W = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  din;
   logic          frame_valid;
   logic          frame_ack;
`ifdef DEMUX_ADDR_EN
   logic [2:0]    addr;

   modport master (
      output in_valid, din, addr, frame_ack,
      input  in_ready, frame_valid
   );

   modport slave (
      input  in_valid, din, addr, frame_ack,
      output in_ready, frame_valid
   );
`else
   modport master (
      output in_valid, din, frame_ack,
      input  in_ready, frame_valid
   );

   modport slave (
      input  in_valid, din, frame_ack,
      output in_ready, frame_valid
   );
`endif
endinterface

// File: rtl/demux_1x8_frame.sv
// -----------------------------------------------------------------------------
// demux_1x8_frame
// Collects eight W-bit words into eight registered output slots and presents
// them as one frame. While a frame is held, the input is stalled until the
// consumer acknowledges the frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears state and all slots)
//   clr          synchronous frame restart (slot data is kept)
//   bus          demux_1x8_frame_if.slave: in_valid/in_ready/din[/addr],
//                frame_valid/frame_ack
//   q0..q7       registered slot outputs
//   slot         index of the next slot to be written
//
// Optional macro: DEMUX_ADDR_EN selects addressed mode. Each transfer then
// writes q[addr], a fill mask tracks written slots and the frame completes
// when every slot has been written at least once. Without it, slots are
// filled strictly in order 0..7.
// -----------------------------------------------------------------------------
module demux_1x8_frame #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   demux_1x8_frame_if.slave bus,
   output logic [W-1:0]     q0,
   output logic [W-1:0]     q1,
   output logic [W-1:0]     q2,
   output logic [W-1:0]     q3,
   output logic [W-1:0]     q4,
   output logic [W-1:0]     q5,
   output logic [W-1:0]     q6,
   output logic [W-1:0]     q7,
   output logic [2:0]       slot
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic         wr_en;
   logic [2:0]   wr_idx;
   logic [W-1:0] q_r [8];

`ifdef DEMUX_ADDR_EN
   logic [7:0]   mask_q;
   logic [7:0]   mask_d;
   logic [7:0]   mask_set;
   logic [2:0]   slot_low;
`else
   logic [2:0]   slot_q;
   logic [2:0]   slot_d;
`endif

   // Handshake outputs come straight from the registered state.
   assign bus.in_ready    = (state_q == FILL);
   assign bus.frame_valid = (state_q == HOLD);

   // Next-state logic. clr wins over both a transfer and a frame_ack; a
   // transfer is only possible in FILL, and frame_ack only matters in HOLD.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
`ifdef DEMUX_ADDR_EN
      mask_d   = mask_q;
      wr_idx   = bus.addr;
      mask_set = mask_q | (8'd1 << bus.addr);
`else
      slot_d   = slot_q;
      wr_idx   = slot_q;
`endif
      if (clr) begin
         state_d = FILL;
`ifdef DEMUX_ADDR_EN
         mask_d  = 8'd0;
`else
         slot_d  = 3'd0;
`endif
      end else begin
         unique case (state_q)
            FILL: begin
               if (bus.in_valid) begin
                  wr_en = 1'b1;
`ifdef DEMUX_ADDR_EN
                  mask_d = mask_set;
                  if (mask_set == 8'hFF) begin
                     state_d = HOLD;
                  end
`else
                  slot_d = slot_q + 3'd1;
                  if (slot_q == 3'd7) begin
                     state_d = HOLD;
                  end
`endif
               end
            end
            HOLD: begin
               if (bus.frame_ack) begin
                  state_d = FILL;
`ifdef DEMUX_ADDR_EN
                  mask_d  = 8'd0;
`else
                  slot_d  = 3'd0;
`endif
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
`ifdef DEMUX_ADDR_EN
         mask_q  <= 8'd0;
`else
         slot_q  <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
`ifdef DEMUX_ADDR_EN
         mask_q  <= mask_d;
`else
         slot_q  <= slot_d;
`endif
      end
   end

   // Slot storage; only reset clears the data, clr and frame_ack keep it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            q_r[i] <= '0;
         end
      end else if (wr_en) begin
         q_r[wr_idx] <= bus.din;
      end
   end

`ifdef DEMUX_ADDR_EN
   // Lowest unfilled slot; the downward scan leaves the smallest index last.
   always_comb begin
      slot_low = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!mask_q[i]) begin
            slot_low = 3'(i);
         end
      end
   end

   assign slot = (state_q == HOLD) ? 3'd0 : slot_low;
`else
   assign slot = slot_q;
`endif

   assign q0 = q_r[0];
   assign q1 = q_r[1];
   assign q2 = q_r[2];
   assign q3 = q_r[3];
   assign q4 = q_r[4];
   assign q5 = q_r[5];
   assign q6 = q_r[6];
   assign q7 = q_r[7];

endmodule

// File: tb/tb_demux_1x8_frame.sv
// -----------------------------------------------------------------------------
// tb_demux_1x8_frame
// Self-checking bench for demux_1x8_frame (W=4). A frame-level reference model
// (words accepted so far, hold flag, slot contents) predicts every output.
// Optional macro: DEMUX_ADDR_EN also exercises addressed mode.
// -----------------------------------------------------------------------------
module tb_demux_1x8_frame;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
   logic [2:0]   slot;
   logic [W-1:0] q_obs [8];

   int vectors;
   int miscompares;

   // Reference model: contents of the eight slots, frame progress, hold flag.
   logic [W-1:0] m_q [8];
   int           m_count;
   bit           m_hold;
   logic [7:0]   m_mask;
   bit           addr_manual;

   demux_1x8_frame_if #(.W(W)) bus ();

   demux_1x8_frame #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus),
      .q0    (q0),
      .q1    (q1),
      .q2    (q2),
      .q3    (q3),
      .q4    (q4),
      .q5    (q5),
      .q6    (q6),
      .q7    (q7),
      .slot  (slot)
   );

   assign q_obs[0] = q0;
   assign q_obs[1] = q1;
   assign q_obs[2] = q2;
   assign q_obs[3] = q3;
   assign q_obs[4] = q4;
   assign q_obs[5] = q5;
   assign q_obs[6] = q6;
   assign q_obs[7] = q7;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected slot index from the model's frame progress.
   function automatic logic [2:0] exp_slot();
`ifdef DEMUX_ADDR_EN
      if (m_hold) return 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!m_mask[i]) return 3'(i);
      end
      return 3'd0;
`else
      return 3'(m_count);
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_q[i] = '0;
      m_count = 0;
      m_mask  = 8'd0;
      m_hold  = 1'b0;
   endtask

   // One clock: inputs already set at the falling edge, model steps on the
   // rising edge, bench resumes at the next falling edge to sample outputs.
   task automatic cycle();
      int idx;
`ifdef DEMUX_ADDR_EN
      if (!addr_manual) bus.addr = exp_slot();
`endif
      @(posedge clk);
      if (clr) begin
         m_count = 0;
         m_mask  = 8'd0;
         m_hold  = 1'b0;
      end else if (m_hold) begin
         if (bus.frame_ack) begin
            m_hold  = 1'b0;
            m_count = 0;
            m_mask  = 8'd0;
         end
      end else if (bus.in_valid) begin
`ifdef DEMUX_ADDR_EN
         idx = int'(bus.addr);
`else
         idx = m_count;
`endif
         m_q[idx] = bus.din;
         m_count  = m_count + 1;
         m_mask[idx] = 1'b1;
`ifdef DEMUX_ADDR_EN
         if (m_mask == 8'hFF) begin
`else
         if (m_count == 8) begin
`endif
            m_hold  = 1'b1;
            m_count = 0;
            m_mask  = 8'd0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.frame_ack = 1'b0;
      clr           = 1'b0;
`ifdef DEMUX_ADDR_EN
      bus.addr      = 3'd0;
`endif
   endtask

   task automatic test_reset();
      idle_inputs();
      addr_manual = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q_obs[i] !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_q%0d: got %h expected 0", i, q_obs[i]);
         end
      end
      vectors++;
      if (slot !== 3'd0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: slot=%0d fv=%b rdy=%b expected 0/0/1",
                  slot, bus.frame_valid, bus.in_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential_fill();
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.din      = 4'(k + 1);
         cycle();
         vectors++;
         if (slot !== exp_slot() || bus.frame_valid !== m_hold) begin
            miscompares++;
            $display("[TB] FAIL seq_fill_step%0d: slot=%0d fv=%b expected %0d/%b",
                     k, slot, bus.frame_valid, exp_slot(), m_hold);
         end
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.frame_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL seq_fill_done: fv=%b rdy=%b expected 1/0",
                  bus.frame_valid, bus.in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q_obs[i] !== 4'(i + 1)) begin
            miscompares++;
            $display("[TB] FAIL seq_fill_q%0d: got %h expected %h", i, q_obs[i], 4'(i + 1));
         end
      end
   endtask

   task automatic test_hold_backpressure();
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1;
         bus.din      = 4'hF;
         cycle();
         vectors++;
         if (bus.frame_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_ctrl%0d: fv=%b rdy=%b expected 1/0",
                     k, bus.frame_valid, bus.in_ready);
         end
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (q_obs[i] !== m_q[i]) begin
               miscompares++;
               $display("[TB] FAIL hold_q%0d: got %h expected %h", i, q_obs[i], m_q[i]);
            end
         end
      end
      bus.in_valid  = 1'b0;
      bus.frame_ack = 1'b1;
      cycle();
      bus.frame_ack = 1'b0;
      vectors++;
      if (bus.frame_valid !== 1'b0 || slot !== 3'd0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL hold_ack: fv=%b slot=%0d rdy=%b expected 0/0/1",
                  bus.frame_valid, slot, bus.in_ready);
      end
   endtask

   task automatic test_clear_priority();
      logic [W-1:0] old_q3;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.din      = 4'($urandom_range(0, 15));
         cycle();
      end
      old_q3       = m_q[3];
      clr          = 1'b1;
      bus.in_valid = 1'b1;
      bus.din      = 4'hA;
      cycle();
      clr          = 1'b0;
      bus.in_valid = 1'b0;
      vectors++;
      if (slot !== 3'd0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL clr_ctrl: slot=%0d fv=%b rdy=%b expected 0/0/1",
                  slot, bus.frame_valid, bus.in_ready);
      end
      vectors++;
      if (q3 !== old_q3) begin
         miscompares++;
         $display("[TB] FAIL clr_q3: got %h expected %h", q3, old_q3);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q_obs[i] !== m_q[i]) begin
            miscompares++;
            $display("[TB] FAIL clr_q%0d: got %h expected %h", i, q_obs[i], m_q[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.din      = 4'($urandom_range(1, 15));
         cycle();
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.frame_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL areset_prehold: fv=%b expected 1", bus.frame_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q_obs[i] !== '0) begin
            miscompares++;
            $display("[TB] FAIL areset_q%0d: got %h expected 0", i, q_obs[i]);
         end
      end
      vectors++;
      if (bus.frame_valid !== 1'b0 || slot !== 3'd0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL areset_ctrl: fv=%b slot=%0d rdy=%b expected 0/0/1",
                  bus.frame_valid, slot, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.din      = 4'h9;
      cycle();
      bus.in_valid = 1'b0;
      vectors++;
      if (q0 !== 4'h9 || slot !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL areset_first: q0=%h slot=%0d expected 9/1", q0, slot);
      end
   endtask

   task automatic test_gapped_input();
      logic [W-1:0] data [8];
      int sent;
      int n;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) data[i] = 4'($urandom_range(0, 15));
      sent = 0;
      n    = 0;
      while (sent < 8 && n < 200) begin
         bus.in_valid = ($urandom_range(0, 2) == 0);
         bus.din      = bus.in_valid ? data[sent] : 4'($urandom_range(0, 15));
         cycle();
         if (bus.in_valid) sent++;
         n++;
         vectors++;
         if (bus.frame_valid !== (sent == 8)) begin
            miscompares++;
            $display("[TB] FAIL gap_fv: got %b expected %b after %0d words",
                     bus.frame_valid, (sent == 8), sent);
         end
      end
      bus.in_valid = 1'b0;
      if (sent < 8) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL gap_budget: sent %0d expected 8", sent);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (q_obs[i] !== data[i]) begin
            miscompares++;
            $display("[TB] FAIL gap_q%0d: got %h expected %h", i, q_obs[i], data[i]);
         end
      end
      bus.frame_ack = 1'b1;
      cycle();
      bus.frame_ack = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         bus.in_valid  = ($urandom_range(0, 1) == 1);
         bus.din       = 4'($urandom_range(0, 15));
         bus.frame_ack = ($urandom_range(0, 2) == 0);
         clr           = ($urandom_range(0, 15) == 0);
         cycle();
         vectors++;
         if (slot !== exp_slot() || bus.frame_valid !== m_hold
             || bus.in_ready !== !m_hold) begin
            miscompares++;
            $display("[TB] FAIL rand_ctrl%0d: slot=%0d fv=%b rdy=%b expected %0d/%b/%b",
                     k, slot, bus.frame_valid, bus.in_ready, exp_slot(), m_hold, !m_hold);
         end
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (q_obs[i] !== m_q[i]) begin
               miscompares++;
               $display("[TB] FAIL rand_q%0d: got %h expected %h", i, q_obs[i], m_q[i]);
            end
         end
      end
      idle_inputs();
   endtask

`ifdef DEMUX_ADDR_EN
   task automatic test_addressed();
      logic [2:0]   seq [9];
      logic [W-1:0] val;
      seq = '{3'd7, 3'd0, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      addr_manual = 1'b1;
      for (int k = 0; k < 9; k++) begin
         val          = 4'(k + 1);
         bus.in_valid = 1'b1;
         bus.addr     = seq[k];
         bus.din      = val;
         cycle();
         vectors++;
         if (bus.frame_valid !== (k == 8) || slot !== exp_slot()) begin
            miscompares++;
            $display("[TB] FAIL addr_step%0d: fv=%b slot=%0d expected %b/%0d",
                     k, bus.frame_valid, slot, (k == 8), exp_slot());
         end
      end
      bus.in_valid = 1'b0;
      addr_manual  = 1'b0;
      vectors++;
      if (q7 !== 4'h3 || q0 !== 4'h2) begin
         miscompares++;
         $display("[TB] FAIL addr_q7: q7=%h q0=%h expected 3/2", q7, q0);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      addr_manual = 1'b0;
      test_reset();
      test_sequential_fill();
      test_hold_backpressure();
      test_clear_priority();
      test_async_reset();
      test_gapped_input();
      test_random();
`ifdef DEMUX_ADDR_EN
      test_addressed();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
